// File: rtl/afifo_rd_sched.sv
// Read-side scheduler for a bank of async FIFOs.
// Round-robin burst drain into one tagged valid/ready stream.
module afifo_rd_sched #(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_r,
    input  logic            rst_n,
    input  logic [N-1:0]    fifo_empty,
    input  logic [N*DW-1:0] fifo_dout,
    output logic [N-1:0]    fifo_re,
    input  logic [N-1:0]    ch_en,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [CW-1:0]   out_ch,
    input  logic            out_ready,
    output logic            busy
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_gnt;
    logic [CW-1:0] r_rr;
    logic [7:0]    r_bcnt;
    logic          r_infl;
    logic [CW-1:0] r_rd_ch;
    logic [DW-1:0] r_mem_d [2];
    logic [CW-1:0] r_mem_c [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_cnt;

    logic [N-1:0]  w_req;
    logic          w_found;
    logic [CW-1:0] w_pick;
    int            w_idx;
    logic          w_pop;
    logic [2:0]    w_occ;
    logic          w_space;
    logic          w_gnt_req;
    logic          w_issue;
    logic          w_last;
    logic [N-1:0]  w_re;

    assign w_req     = ~fifo_empty & ch_en;
    assign out_valid = (r_cnt != 2'd0);
    assign out_data  = r_mem_d[r_rp];
    assign out_ch    = r_mem_c[r_rp];
    assign w_pop     = out_valid & out_ready;
    // buffered + in flight after this cycle's pop must leave a free slot
    assign w_occ     = {1'b0, r_cnt} + {2'b0, r_infl} - {2'b0, w_pop};
    assign w_space   = (w_occ <= 3'd1);
    assign w_gnt_req = w_req[r_gnt];
    assign w_issue   = (r_state == S_BURST) & w_gnt_req & w_space;
    assign w_last    = (r_bcnt == 8'(BURST - 1));
    assign busy      = (r_state == S_BURST) | r_infl | out_valid;
    assign fifo_re   = w_re;

    // round-robin pick: first requester after r_rr, cyclic upward
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 1; i <= N; i++) begin
            w_idx = (int'(r_rr) + i) % N;
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = CW'(w_idx);
            end
        end
    end

    // one-hot read enable toward the granted FIFO
    always_comb begin
        w_re = '0;
        if (w_issue) begin
            w_re[r_gnt] = 1'b1;
        end
    end

    // next-state: enter on any request, leave on limit/empty/mask
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if ((w_issue && w_last) || !w_gnt_req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // state, grant, pointer and burst counter
    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_rr    <= CW'(N - 1);
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && w_found) begin
                r_gnt  <= w_pick;
                r_rr   <= w_pick;
                r_bcnt <= '0;
            end else if (w_issue) begin
                r_bcnt <= r_bcnt + 8'd1;
            end
        end
    end

    // in-flight flag: FIFO data appears the cycle after re
    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            r_infl  <= 1'b0;
            r_rd_ch <= '0;
        end else begin
            r_infl <= w_issue;
            if (w_issue) begin
                r_rd_ch <= r_gnt;
            end
        end
    end

    // two-entry output buffer, push from in-flight read, pop on handshake
    always_ff @(posedge clk_r or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_d[0] <= '0;
            r_mem_d[1] <= '0;
            r_mem_c[0] <= '0;
            r_mem_c[1] <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            if (r_infl) begin
                r_mem_d[r_wp] <= fifo_dout[int'(r_rd_ch)*DW +: DW];
                r_mem_c[r_wp] <= r_rd_ch;
                r_wp          <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_cnt <= r_cnt + {1'b0, r_infl} - {1'b0, w_pop};
        end
    end

endmodule

// File: doc/afifo_rd_sched.md
# afifo_rd_sched

Read-side scheduler for a bank of N asynchronous FIFOs in the clk_r domain. Watches each FIFO's `empty`, drives each FIFO's `re`, and captures the registered FIFO `dout`. Drains channels round-robin in bursts of up to BURST words into one valid/ready stream tagged with the channel number. Sits between the CDC FIFOs and the single read-domain consumer.

## Interface
- N, 4: number of FIFO channels (2..16).
- DW, 8: FIFO data width.
- BURST, 4: maximum reads per grant (1..255).
- CW, $clog2(N): channel-id width (derived).
- clk_r  in  1  read-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- fifo_empty  in  N  per-channel FIFO empty flag.
- fifo_dout  in  N*DW  per-channel FIFO read data; channel k is bits [k*DW +: DW]. Valid the cycle after `re`.
- fifo_re  out  N  per-channel read enable, one-hot or zero.
- ch_en  in  N  channel enable mask; 0 excludes the channel from arbitration.
- out_valid  out  1  output word valid.
- out_data  out  DW  output word.
- out_ch  out  CW  source channel of out_data.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- busy  out  1  high when state is BURST, when a read is in flight, or when the buffer is non-empty.

## Operation
- **Reset values:** fifo_re=0, out_valid=0, out_data=0, out_ch=0, busy=0, state=IDLE, rr_ptr=N-1 (so channel 0 wins first), burst_cnt=0, buffer empty, in-flight flag cleared.
- **Request vector:** req[k] = ~fifo_empty[k] & ch_en[k].
- **State IDLE**
  - If req≠0, grant the first requesting channel after rr_ptr, searching cyclically upward.
  - Register the grant as gnt, set rr_ptr=gnt, clear burst_cnt, and go to BURST.
  - No fifo_re is issued in IDLE.
- **State BURST (combinational read enable)**
  - fifo_re[gnt] = ~fifo_empty[gnt] & ch_en[gnt] & space.
  - space = (buf_cnt + inflight − pop) ≤ 1, where pop = out_valid & out_ready.
  - Every issued read increments burst_cnt.
- **BURST exit to IDLE.** Any one of these conditions:
  - a read is issued with burst_cnt==BURST−1;
  - fifo_empty[gnt]=1;
  - ch_en[gnt]=0.
  - Stalling for space does not exit the burst.
- **In-flight tracking.** A read issued in cycle t sets inflight=1 and rd_ch=gnt at edge t. In cycle t+1 the word fifo_dout[rd_ch] is written into a 2-entry buffer together with rd_ch.
- **Output buffer**
  - 2-entry FIFO, head drives out_data/out_ch, out_valid = buf_cnt≠0.
  - Simultaneous push and pop is allowed at any occupancy; buf_cnt never exceeds 2.
- **Ordering.** Words leave in issue order. The buffer empties naturally, so channels never interleave inside the buffer out of order.
- **Reset mid-operation.** Everything returns to reset values and in-flight or buffered words are discarded. The FIFO's own read pointer has already advanced, so those words are lost by design.

## Timing
- Latency from fifo_re high in cycle t to out_valid high is 2 cycles (cycle t+2), when the buffer was empty.
- With out_ready held high, throughput is 1 word/cycle within a burst.
- Each IDLE→BURST transition costs 1 bubble cycle.
- Under backpressure (out_ready=0), at most 2 reads are outstanding (buffered plus in flight). fifo_re stays low until a pop occurs.
- out_valid, out_data and out_ch are registered and stay stable while out_valid & ~out_ready.
- fifo_empty is sampled combinationally each cycle. A FIFO emptying in the cycle after a read is honoured with no extra read.

## Test plan
- **Single-channel drain.** ch0 holds 3 words A,B,C, ch_en=4'b1111, out_ready=1.
  - fifo_re[0] pulses 3 consecutive cycles.
  - out emits A,B,C with out_ch=0, first word 3 cycles after fifo_empty[0] falls (1 IDLE + 2 latency).
  - busy then drops.
- **Round-robin and burst limit.** ch0..ch3 each hold 6 words, BURST=4.
  - out_ch sequence: 0×4, 1×4, 2×4, 3×4, 0×2, 1×2, 2×2, 3×2.
  - Per-channel data arrives in FIFO order.
- **Backpressure.** ch1 holds 5 words, out_ready=0 for 10 cycles, then 1.
  - Exactly 2 fifo_re pulses occur during the stall.
  - out_valid stays high with out_data stable.
  - All 5 words are then delivered in order.
- **Early empty and masking.**
  - ch2 holds 2 words with BURST=4: the burst ends after 2 reads and ch3 is granted next.
  - With ch_en[3]=0 and ch3 non-empty: fifo_re[3] is never asserted.
- **Reset mid-burst.** Assert rst_n=0 during the third read of a burst.
  - All outputs go to their reset values immediately.
  - After release, arbitration restarts at channel 0.
- **Read never issued on empty.** Random empty toggling on all channels.
  - Assertion: fifo_re[k] & fifo_empty[k] never true.
  - Assertion: fifo_re has at most one bit set.
